// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller slice.
// Register offsets (word offset = Addr[1:0]), CPU interrupt vector width,
// CAUSE register field positions and the device base address used by the
// Bridge decoder.
package irq_pkg;

   typedef enum logic [1:0] {
      OFF_PEND  = 2'd0,
      OFF_MASK  = 2'd1,
      OFF_MODE  = 2'd2,
      OFF_CAUSE = 2'd3
   } reg_off_e;

   localparam int unsigned N_HWINT = 6;

   // CAUSE = {valid, cnt[22:0], count_sat, 4'b0, idx[2:0]}
   localparam int unsigned CAUSE_VALID_BIT = 31;
   localparam int unsigned CAUSE_CNT_MSB   = 30;
   localparam int unsigned CAUSE_CNT_LSB   = 8;
   localparam int unsigned CAUSE_CNT_W     = 23;
   localparam int unsigned CAUSE_SAT_BIT   = 7;
   localparam int unsigned CAUSE_IDX_MSB   = 2;
   localparam int unsigned CAUSE_IDX_W     = 3;

   localparam logic [31:0] IRQ_BASE_ADDR = 32'h0000_7F20;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder, purely combinational.
// Ports:
//   req   - request vector (N_SRC bits)
//   idx   - index of the lowest-numbered set bit (0 when none set)
//   valid - any bit of req set
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int unsigned N_SRC = 6
) (
   input  logic [N_SRC-1:0]       req,
   output logic [CAUSE_IDX_W-1:0] idx,
   output logic                   valid
);

   logic found;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req[i] && !found) begin
            idx   = CAUSE_IDX_W'(i);
            found = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller between peripheral request lines and
// the CPU HWInt input. Requests are double-sampled, latched into a pending
// register (edge or level per source), masked, and priority encoded.
// Ports:
//   clk, reset      - system clock, synchronous active-low reset
//   Addr, WE, Din   - Bridge slave write side (only Addr[1:0] decoded)
//   Dout            - read data, combinational on Addr
//   irq_src         - raw asynchronous request lines
//   HWInt           - pend & mask, zero-extended to 6 bits
//   IRQ             - OR of HWInt
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned N_SRC = 6,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [29:0]        Addr,
   input  logic               WE,
   input  logic [31:0]        Din,
   output logic [31:0]        Dout,
   input  logic [N_SRC-1:0]   irq_src,
   output logic [N_HWINT-1:0] HWInt,
   output logic               IRQ
);

   logic [N_SRC-1:0]       s1, s2, pend, mask, mode;
   logic [N_SRC-1:0]       rise, clr, pend_nxt, act, ev;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [CNT_W+2:0]       cnt_sum;
   logic [2:0]             inc;
   logic                   sat;
   logic                   we_pend, we_mask, we_mode, we_cause;
   logic [CAUSE_IDX_W-1:0] idx;
   logic                   valid;
   logic [CAUSE_CNT_W-1:0] cnt_field;
   logic [31:0]            cause;
   logic                   unused_bits;

   assign unused_bits = ^{Addr[29:2], Din[31:N_SRC]};

   assign we_pend  = WE && (Addr[1:0] == OFF_PEND);
   assign we_mask  = WE && (Addr[1:0] == OFF_MASK);
   assign we_mode  = WE && (Addr[1:0] == OFF_MODE);
   assign we_cause = WE && (Addr[1:0] == OFF_CAUSE);

   assign rise = s1 & ~s2;
   assign clr  = we_pend ? Din[N_SRC-1:0] : '0;
   assign act  = pend & mask;
   assign ev   = rise & mode & mask;

   // Edge bits: a same-cycle rise overrides the W1C so no event is lost.
   // Level bits simply follow the synchronised input.
   assign pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & s1);

   always_comb begin
      inc = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         inc = inc + {2'b00, ev[i]};
      end
   end

   // Three guard bits hold any carry past the counter width; a carry clamps.
   assign cnt_sum = {3'b000, cnt} + {{CNT_W{1'b0}}, inc};
   assign cnt_nxt = (|cnt_sum[CNT_W+2:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];

   // A saturated counter only leaves all-ones through a clear, so the flag
   // is sticky without needing its own register.
   assign sat = &cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= '0;
         s2   <= '0;
         pend <= '0;
         mask <= '0;
         mode <= '0;
         cnt  <= '0;
      end else begin
         s1   <= irq_src;
         s2   <= s1;
         pend <= pend_nxt;
         if (we_mask) mask <= Din[N_SRC-1:0];
         if (we_mode) mode <= Din[N_SRC-1:0];
         cnt  <= we_cause ? '0 : cnt_nxt;
      end
   end

   irq_prio_enc #(
      .N_SRC (N_SRC)
   ) u_prio (
      .req   (act),
      .idx   (idx),
      .valid (valid)
   );

   generate
      if (CNT_W >= CAUSE_CNT_W) begin : g_cnt_trunc
         assign cnt_field = cnt[CAUSE_CNT_W-1:0];
      end else begin : g_cnt_ext
         assign cnt_field = {{(CAUSE_CNT_W-CNT_W){1'b0}}, cnt};
      end
   endgenerate

   always_comb begin
      cause                              = '0;
      cause[CAUSE_VALID_BIT]             = valid;
      cause[CAUSE_CNT_MSB:CAUSE_CNT_LSB] = cnt_field;
      cause[CAUSE_SAT_BIT]               = sat;
      cause[CAUSE_IDX_MSB:0]             = idx;
   end

   always_comb begin
      Dout = '0;
      case (Addr[1:0])
         OFF_PEND:  Dout[N_SRC-1:0] = pend;
         OFF_MASK:  Dout[N_SRC-1:0] = mask;
         OFF_MODE:  Dout[N_SRC-1:0] = mode;
         OFF_CAUSE: Dout            = cause;
         default:   Dout            = '0;
      endcase
   end

   always_comb begin
      HWInt            = '0;
      HWInt[N_SRC-1:0] = act;
      IRQ              = |act;
   end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
   import irq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic [5:0]  irq_src;
   logic [5:0]  HWInt;
   logic        IRQ;

   irq_ctrl #(
      .N_SRC (6),
      .CNT_W (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .Addr    (Addr),
      .WE      (WE),
      .Din     (Din),
      .Dout    (Dout),
      .irq_src (irq_src),
      .HWInt   (HWInt),
      .IRQ     (IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] dout;
      logic [5:0]  hw;
   } exp_t;

   exp_t sb[$];
   logic rd_valid = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   // Monitor: whenever a read is presented, pop the expectation and compare.
   always @(negedge clk) begin
      if (rd_valid) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %0t no_expectation: read presented with empty scoreboard", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (Dout !== e.dout || HWInt !== e.hw || IRQ !== (|e.hw)) begin
               n_fail++;
               $display("FAIL %0t %s: Dout=%h HWInt=%h IRQ=%b, required Dout=%h HWInt=%h IRQ=%b",
                        $time, e.nm, Dout, HWInt, IRQ, e.dout, e.hw, |e.hw);
            end
         end
      end
   end

   task automatic cyc(input logic [1:0] off, input logic we_i, input logic [31:0] d,
                      input bit do_chk, input logic [31:0] ed, input logic [5:0] eh,
                      input string nm);
      exp_t e;
      Addr = {28'd0, off};
      WE   = we_i;
      Din  = d;
      rd_valid = do_chk;
      if (do_chk) begin
         e.nm = nm; e.dout = ed; e.hw = eh;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(OFF_PEND, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0, "");
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      cyc(off, 1'b1, d, 1'b0, 32'd0, 6'd0, "");
   endtask

   task automatic chk(input string nm, input logic [1:0] off, input logic [31:0] ed,
                      input logic [5:0] eh);
      cyc(off, 1'b0, 32'd0, 1'b1, ed, eh, nm);
   endtask

   task automatic pulse0(input int n);
      for (int i = 0; i < n; i++) begin
         irq_src = 6'h01; idle(1);
         irq_src = 6'h00; idle(1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; Addr = '0; WE = 1'b0; Din = '0; irq_src = 6'h3F;
      @(posedge clk); #1;
      // Reset with active requests and writes: reset must dominate.
      for (int i = 0; i < 3; i++) cyc(OFF_MASK, 1'b1, 32'h3F, 1'b0, 32'd0, 6'd0, "");
      cyc(OFF_MODE, 1'b1, 32'h3F, 1'b0, 32'd0, 6'd0, "");
      reset = 1'b1; irq_src = 6'h00;
      chk("rst_pend",  OFF_PEND,  32'h0, 6'h0);
      chk("rst_mask",  OFF_MASK,  32'h0, 6'h0);
      chk("rst_mode",  OFF_MODE,  32'h0, 6'h0);
      chk("rst_cause", OFF_CAUSE, 32'h0, 6'h0);

      // Edge latency and W1C on a held-high source. cnt -> 1.
      wr(OFF_MODE, 32'h3F);
      wr(OFF_MASK, 32'h01);
      irq_src = 6'h01;
      chk("lat_k",     OFF_PEND, 32'h0, 6'h00);
      chk("lat_k1",    OFF_PEND, 32'h0, 6'h00);
      chk("lat_k2",    OFF_PEND, 32'h1, 6'h01);
      wr(OFF_PEND, 32'h1);
      chk("w1c_clr",   OFF_PEND, 32'h0, 6'h00);
      idle(3);
      chk("held_once", OFF_PEND, 32'h0, 6'h00);
      irq_src = 6'h00;

      // Priority: sources 1 and 2 together. cnt -> 3.
      wr(OFF_MASK, 32'h06);
      irq_src = 6'h06; idle(1);
      irq_src = 6'h00; idle(1);
      chk("prio_idx1", OFF_CAUSE, 32'h8000_0301, 6'h06);
      wr(OFF_PEND, 32'h2);
      chk("prio_idx2", OFF_CAUSE, 32'h8000_0302, 6'h04);
      wr(OFF_PEND, 32'h4);
      chk("prio_none", OFF_CAUSE, 32'h0000_0300, 6'h00);

      // Set/clear race on bit 0. cnt -> 4.
      wr(OFF_MASK, 32'h01);
      irq_src = 6'h01; idle(1);
      wr(OFF_PEND, 32'h1);
      chk("race_set_wins", OFF_PEND, 32'h1, 6'h01);
      irq_src = 6'h00;
      wr(OFF_PEND, 32'h1);
      chk("race_cleanup",  OFF_PEND, 32'h0, 6'h00);

      // Level mode: 5-cycle request on source 3, W1C inside the window.
      wr(OFF_MODE, 32'h0);
      wr(OFF_MASK, 32'h08);
      for (int k = 0; k < 8; k++) begin
         logic [5:0] ev;
         ev = (k >= 2 && k <= 6) ? 6'h08 : 6'h00;
         irq_src = (k < 5) ? 6'h08 : 6'h00;
         cyc(OFF_PEND, (k == 3), 32'h8, 1'b1, {26'd0, ev}, ev, $sformatf("level_k%0d", k));
      end

      // Event counter (CNT_W=4) saturation and clear.
      wr(OFF_CAUSE, 32'h0);
      chk("cnt_clr0",   OFF_CAUSE, 32'h0, 6'h00);
      wr(OFF_MODE, 32'h01);
      wr(OFF_MASK, 32'hFFFF_FFC1);
      chk("mask_unimpl", OFF_MASK, 32'h1, 6'h00);
      pulse0(14); idle(2);
      chk("cnt_14",     OFF_CAUSE, 32'h8000_0E00, 6'h01);
      pulse0(2); idle(2);
      chk("cnt_sat",    OFF_CAUSE, 32'h8000_0F80, 6'h01);
      pulse0(1); idle(2);
      chk("cnt_hold",   OFF_CAUSE, 32'h8000_0F80, 6'h01);
      wr(OFF_CAUSE, 32'hFFFF_FFFF);
      chk("cnt_clr",    OFF_CAUSE, 32'h8000_0000, 6'h01);
      irq_src = 6'h01; idle(1);
      irq_src = 6'h00;
      wr(OFF_CAUSE, 32'h0);
      chk("cnt_clr_wins", OFF_CAUSE, 32'h8000_0000, 6'h01);
      pulse0(1); idle(2);
      chk("cnt_after",  OFF_CAUSE, 32'h8000_0100, 6'h01);

      idle(1);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
